// File: rtl/decade_pkg.sv
// decade_pkg
//   Shared constants, FSM state type and the one-hot decode helper for the
//   decade phase encoder.
//   DECADE_N   : number of phases produced by the decade counter.
//   PHASE_W    : width of the binary phase index.
//   CO_SPLIT   : highest phase for which the counter holds _co high.
//   LAST_PHASE : phase after which the counter wraps back to 0.
//   PHASE0_VEC : one-hot vector for phase 0 (counter reset value).
package decade_pkg;

  localparam int DECADE_N = 10;
  localparam int PHASE_W  = 4;
  localparam int CO_SPLIT = 4;

  localparam logic [PHASE_W-1:0]  LAST_PHASE = PHASE_W'(DECADE_N - 1);
  localparam logic [DECADE_N-1:0] PHASE0_VEC = DECADE_N'(1);

  typedef enum logic {
    SEEK  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Returns {legal, index}. legal is set only when exactly one bit is high;
  // index is the position of the highest set bit (meaningful only if legal).
  function automatic logic [PHASE_W:0] onehot_to_index(input logic [DECADE_N-1:0] vec);
    logic [PHASE_W-1:0] idx;
    logic               seen;
    logic               multi;
    idx   = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < DECADE_N; i++) begin
      if (vec[i]) begin
        if (seen) begin
          multi = 1'b1;
        end
        seen = 1'b1;
        idx  = PHASE_W'(i);
      end
    end
    return {seen & ~multi, idx};
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff
//   Chain of STAGES flops bringing an asynchronous bus into the i_clk domain.
//   Every stage loads RST_VAL on a synchronous active-low reset.
//   i_clk   : sampling clock (rising edge).
//   i_rst_n : synchronous active-low reset.
//   i_d     : asynchronous input bus.
//   o_q     : synchronised bus, STAGES cycles behind i_d.
module sync_ff #(
  parameter int                WIDTH   = 1,
  parameter int                STAGES  = 2,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] r_q;
      if (gi == 0) begin : g_first
        always_ff @(posedge i_clk) begin
          if (!i_rst_n) begin
            r_q <= RST_VAL;
          end else begin
            r_q <= i_d;
          end
        end
      end else begin : g_chain
        always_ff @(posedge i_clk) begin
          if (!i_rst_n) begin
            r_q <= RST_VAL;
          end else begin
            r_q <= g_stage[gi-1].r_q;
          end
        end
      end
    end
  endgenerate

  assign o_q = g_stage[STAGES-1].r_q;

endmodule

// File: rtl/decade_phase_encoder.sv
// decade_phase_encoder
//   Receives the decoded one-hot bus of a decade counter, re-encodes it to a
//   binary phase index and checks that the counter behaves legally.
//   cp         : rising-edge clock.
//   _mr        : synchronous active-low master reset.
//   q          : one-hot phase vector (asynchronous to cp).
//   _co        : counter carry-out (asynchronous), high for phases 0..4.
//   clr_err    : synchronous clear of the sticky flags and error counter.
//   phase      : registered phase index 0..9.
//   valid      : phase holds a checked value (tracking).
//   step       : one-cycle pulse when the phase advanced by one (incl. 9->0).
//   wrap       : one-cycle pulse on 9->0 only.
//   resync     : one-cycle pulse on an n->0 jump, n not 0 or 9.
//   err_onehot : sticky, sampled vector was not one-hot.
//   err_seq    : sticky, illegal phase jump.
//   err_co     : sticky, _co disagreed with the phase.
//   err_count  : saturating count of cycles with any error.
module decade_phase_encoder
  import decade_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8,
  parameter int LOG         = 0
) (
  input  logic                cp,
  input  logic                _mr,
  input  logic [DECADE_N-1:0] q,
  input  logic                _co,
  input  logic                clr_err,
  output logic [PHASE_W-1:0]  phase,
  output logic                valid,
  output logic                step,
  output logic                wrap,
  output logic                resync,
  output logic                err_onehot,
  output logic                err_seq,
  output logic                err_co,
  output logic [ERR_W-1:0]    err_count
);

  // Out-of-range stage counts are rejected at elaboration. This body has no
  // trace output, so LOG is only checked for a sensible value.
  generate
    if (SYNC_STAGES < 1 || SYNC_STAGES > 3 || LOG < 0) begin : g_bad_param
      $error("decade_phase_encoder: SYNC_STAGES must be 1..3 and LOG non-negative");
    end
  endgenerate

  logic [DECADE_N-1:0] w_q_sync;
  logic                w_co_sync;
  logic [PHASE_W:0]    w_dec;
  logic                w_legal;
  logic [PHASE_W-1:0]  w_cand;
  logic                w_co_ok;

  // Synchronisers reset to the counter's own reset state (phase 0, _co high)
  // so the first decode after reset is a legal phase-0 vector.
  sync_ff #(
    .WIDTH   (DECADE_N),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (PHASE0_VEC)
  ) u_sync_q (
    .i_clk   (cp),
    .i_rst_n (_mr),
    .i_d     (q),
    .o_q     (w_q_sync)
  );

  sync_ff #(
    .WIDTH   (1),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_co (
    .i_clk   (cp),
    .i_rst_n (_mr),
    .i_d     (_co),
    .o_q     (w_co_sync)
  );

  assign w_dec   = onehot_to_index(w_q_sync);
  assign w_legal = w_dec[PHASE_W];
  assign w_cand  = w_dec[PHASE_W-1:0];
  assign w_co_ok = (w_co_sync == (w_cand <= PHASE_W'(CO_SPLIT)));

  state_t             r_state;
  logic [PHASE_W-1:0] r_phase;
  logic               r_valid;
  logic               r_step;
  logic               r_wrap;
  logic               r_resync;
  logic               r_err_onehot;
  logic               r_err_seq;
  logic               r_err_co;
  logic [ERR_W-1:0]   r_err_count;

  logic w_ev_oh;
  logic w_ev_seq;
  logic w_ev_co;
  logic w_ev_any;
  logic w_is_step;
  logic w_is_wrap;
  logic w_is_resync;

  // Classify the decoded vector against the last tracked phase. The _co check
  // runs on every legal vector, including the one that locks from SEEK.
  always_comb begin
    w_ev_oh     = ~w_legal;
    w_ev_co     = w_legal & ~w_co_ok;
    w_ev_seq    = 1'b0;
    w_is_step   = 1'b0;
    w_is_wrap   = 1'b0;
    w_is_resync = 1'b0;
    if (r_state == TRACK && w_legal && w_cand != r_phase) begin
      if (r_phase != LAST_PHASE && w_cand == r_phase + PHASE_W'(1)) begin
        w_is_step = 1'b1;
      end else if (r_phase == LAST_PHASE && w_cand == '0) begin
        w_is_step = 1'b1;
        w_is_wrap = 1'b1;
      end else if (w_cand == '0) begin
        w_is_resync = 1'b1;
      end else begin
        w_ev_seq = 1'b1;
      end
    end
    w_ev_any = w_ev_oh | w_ev_seq | w_ev_co;
  end

  always_ff @(posedge cp) begin
    if (!_mr) begin
      r_state      <= SEEK;
      r_phase      <= '0;
      r_valid      <= 1'b0;
      r_step       <= 1'b0;
      r_wrap       <= 1'b0;
      r_resync     <= 1'b0;
      r_err_onehot <= 1'b0;
      r_err_seq    <= 1'b0;
      r_err_co     <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_step   <= w_is_step;
      r_wrap   <= w_is_wrap;
      r_resync <= w_is_resync;

      case (r_state)
        SEEK: begin
          // Lock silently onto the first legal vector.
          if (w_legal) begin
            r_state <= TRACK;
            r_valid <= 1'b1;
            r_phase <= w_cand;
          end
        end
        TRACK: begin
          // On any loss of lock the last good phase stays on the output.
          if (!w_legal || w_ev_seq) begin
            r_state <= SEEK;
            r_valid <= 1'b0;
          end else begin
            r_phase <= w_cand;
          end
        end
        default: begin
          r_state <= SEEK;
          r_valid <= 1'b0;
        end
      endcase

      // A new error in the clearing cycle survives the clear.
      if (clr_err) begin
        r_err_onehot <= w_ev_oh;
        r_err_seq    <= w_ev_seq;
        r_err_co     <= w_ev_co;
        r_err_count  <= w_ev_any ? ERR_W'(1) : '0;
      end else begin
        r_err_onehot <= r_err_onehot | w_ev_oh;
        r_err_seq    <= r_err_seq | w_ev_seq;
        r_err_co     <= r_err_co | w_ev_co;
        if (w_ev_any && r_err_count != '1) begin
          r_err_count <= r_err_count + ERR_W'(1);
        end
      end
    end
  end

  assign phase      = r_phase;
  assign valid      = r_valid;
  assign step       = r_step;
  assign wrap       = r_wrap;
  assign resync     = r_resync;
  assign err_onehot = r_err_onehot;
  assign err_seq    = r_err_seq;
  assign err_co     = r_err_co;
  assign err_count  = r_err_count;

endmodule
